dial_sequencer: RTL

DIAL_SEQUENCER -- requirements
Module: dial_sequencer

---
 rtl/dial_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dial_sequencer.sv
// Instruction FIFO feeding a dial stepping datapath: each queued {direction, count, last}
// entry is issued as a one-cycle load pulse, then the sequencer waits out the step count.
module dial_sequencer #(
    parameter int INPUT_WIDTH = 10,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_direction,
    input  logic [INPUT_WIDTH-1:0]       in_count,
    input  logic                         in_last,
    output logic                         sol_valid,
    output logic                         sol_step_direction,
    output logic [INPUT_WIDTH-1:0]       sol_step_count,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = INPUT_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [INPUT_WIDTH-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [INPUT_WIDTH-1:0]  step_count_reg;
    logic                    step_dir_reg;
    logic                    last_reg;

    logic [ENTRY_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]        level_reg;
    logic [ENTRY_W-1:0]      head;
    logic                    push, pop;

    // A full FIFO refuses input even when a pop frees a slot on the same edge.
    assign in_ready = (level_reg < LVL_W'(FIFO_DEPTH)) && (state_reg != DONE);
    assign push     = in_valid && in_ready;
    assign pop      = (state_reg == IDLE) && (level_reg != '0);
    assign head     = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {in_direction, in_count, in_last};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            wait_cnt_reg   <= '0;
            step_dir_reg   <= 1'b0;
            step_count_reg <= '0;
            last_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (pop) begin
                step_dir_reg   <= head[ENTRY_W-1];
                step_count_reg <= head[ENTRY_W-2:1];
                last_reg       <= head[0];
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pop) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_next = step_count_reg;
                if (step_count_reg == '0) begin
                    state_next = last_reg ? DONE : IDLE;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // Leaving on wait_cnt == 1 makes the next issue land exactly count+2 cycles later.
                wait_cnt_next = wait_cnt_reg - INPUT_WIDTH'(1);
                if (wait_cnt_reg == INPUT_WIDTH'(1)) begin
                    state_next = last_reg ? DONE : IDLE;
                end
            end
            default: begin
                state_next = DONE;
            end
        endcase
    end

    assign sol_valid          = (state_reg == ISSUE);
    assign sol_step_direction = step_dir_reg;
    assign sol_step_count     = step_count_reg;
    assign done               = (state_reg == DONE);
    assign busy               = (state_reg == ISSUE) || (state_reg == WAIT) || (level_reg != '0);
    assign fifo_level         = level_reg;

endmodule
